// File: rtl/line_info_ram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : line_info_ram_ctrl
// Brief   : Single-port neighbour-info RAM client with posted write queue,
//           read-after-write stalls and a picture-start zero-clear sweep.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module line_info_ram_ctrl #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int WQ_BITS   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_pic,
  output logic                 busy,
  output logic                 clear_done,
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_ready,
  output logic                 rd_data_valid,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_wdata,
  input  logic [DATA_BITS-1:0] ram_rdata
);

  localparam int                 c_depth   = 1 << WQ_BITS;
  localparam logic [WQ_BITS:0]   c_ptr_one = 1;
  localparam logic [ADDR_BITS-1:0] c_cnt_one = 1;

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t               r_state;
  logic [ADDR_BITS-1:0] r_clr_cnt;
  logic [WQ_BITS:0]     r_wr_ptr;
  logic [WQ_BITS:0]     r_rd_ptr;
  logic                 r_rd_valid;
  logic [ADDR_BITS-1:0] r_wq_addr [c_depth];
  logic [DATA_BITS-1:0] r_wq_data [c_depth];

  logic [WQ_BITS:0]     w_count;
  logic [WQ_BITS-1:0]   w_head;
  logic                 w_empty;
  logic                 w_full;
  logic [c_depth-1:0]   w_hit;
  logic                 w_hazard;
  logic                 w_in_ready;
  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic                 w_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_head  = r_rd_ptr[WQ_BITS-1:0];
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[WQ_BITS] != r_rd_ptr[WQ_BITS]) &&
                   (r_wr_ptr[WQ_BITS-1:0] == r_rd_ptr[WQ_BITS-1:0]);

  generate
    for (genvar i = 0; i < c_depth; i++) begin : g_hazard
      logic [WQ_BITS-1:0] w_off;
      assign w_off    = WQ_BITS'(i) - w_head;
      assign w_hit[i] = ({1'b0, w_off} < w_count) && (r_wq_addr[i] == rd_addr);
    end
  endgenerate

  assign w_hazard   = |w_hit;
  assign w_in_ready = (r_state == ST_READY);
  assign rd_ready   = w_in_ready && !w_full && !w_hazard;
  assign wr_ready   = w_in_ready && !w_full;
  assign w_rd_acc   = rd_req && rd_ready;
  assign w_wr_acc   = wr_req && wr_ready;
  // A picture start discards the queue, so nothing is popped that cycle.
  assign w_pop      = w_in_ready && !w_rd_acc && !w_empty && !start_pic;

  assign busy          = (r_state == ST_CLEAR);
  assign clear_done    = busy && (&r_clr_cnt) && !start_pic;
  assign rd_data_valid = r_rd_valid;
  assign rd_data       = ram_rdata;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (busy) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = r_clr_cnt;
    end else if (w_rd_acc) begin
      ram_en   = 1'b1;
      ram_addr = rd_addr;
    end else if (w_pop) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = r_wq_addr[w_head];
      ram_wdata = r_wq_data[w_head];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_READY;
      r_clr_cnt  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      case (r_state)
        ST_READY: begin
          if (start_pic) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
          end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + c_ptr_one;
          end
        end
        ST_CLEAR: begin
          if (start_pic) begin
            r_clr_cnt <= '0;
          end else if (&r_clr_cnt) begin
            r_state   <= ST_READY;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + c_cnt_one;
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  // Queue storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_wq_addr[r_wr_ptr[WQ_BITS-1:0]] <= wr_addr;
      r_wq_data[r_wr_ptr[WQ_BITS-1:0]] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_info_ram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_line_info_ram_ctrl
// Brief   : Self-checking bench with RAM model, vector table and scoreboard.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_line_info_ram_ctrl;

  localparam int AB = 4;
  localparam int DB = 16;
  localparam int WQ = 2;
  localparam int DEPTH = 4;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_pic;
  logic          busy, clear_done;
  logic          rd_req;
  logic [AB-1:0] rd_addr;
  logic          rd_ready, rd_data_valid;
  logic [DB-1:0] rd_data;
  logic          wr_req;
  logic [AB-1:0] wr_addr;
  logic [DB-1:0] wr_data;
  logic          wr_ready;
  logic          ram_en, ram_we;
  logic [AB-1:0] ram_addr;
  logic [DB-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  line_info_ram_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .WQ_BITS(WQ)) dut (
    .clk(clk), .rst(rst), .start_pic(start_pic), .busy(busy), .clear_done(clear_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port RAM with registered read and undefined power-up contents.
  logic          scramble;
  logic [DB-1:0] mem [NW];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < NW; i++) mem[i] <= DB'($urandom);
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  int n_pass = 0;
  int n_total = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: logical memory, pending-write list, sweep position.
  typedef struct packed { logic [AB-1:0] a; logic [DB-1:0] d; } wr_t;
  wr_t           mq[$];
  logic [DB-1:0] mmem [NW];
  bit            m_clr, m_pend, m_known;
  int            m_cnt;
  logic [DB-1:0] m_pexp;
  bit            e_rd_acc, e_wr_acc;

  task automatic model_reset();
    mq.delete();
    m_clr = 0; m_pend = 0; m_known = 0; m_cnt = 0;
    e_rd_acc = 0; e_wr_acc = 0;
  endtask

  task automatic model_check();
    bit hz, full, rdy, wrdy, en, we;
    logic [AB-1:0] ea;
    logic [DB-1:0] ed;
    if (rst) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_rd_valid", 32'(rd_data_valid), 32'd0);
      e_rd_acc = 0; e_wr_acc = 0;
      return;
    end
    full = (mq.size() == DEPTH);
    hz = 0;
    foreach (mq[i]) if (mq[i].a == rd_addr) hz = 1;
    rdy  = !m_clr && !full && !hz;
    wrdy = !m_clr && !full;
    e_rd_acc = rd_req && rdy;
    e_wr_acc = wr_req && wrdy;
    en = 0; we = 0; ea = '0; ed = '0;
    if (m_clr) begin
      en = 1; we = 1; ea = AB'(m_cnt);
    end else if (e_rd_acc) begin
      en = 1; ea = rd_addr;
    end else if (mq.size() > 0 && !start_pic) begin
      en = 1; we = 1; ea = mq[0].a; ed = mq[0].d;
    end
    if (clear_done) done_seen++;
    chk("m_busy", 32'(busy), 32'(m_clr));
    chk("m_rd_ready", 32'(rd_ready), 32'(rdy));
    chk("m_wr_ready", 32'(wr_ready), 32'(wrdy));
    chk("m_clear_done", 32'(clear_done), 32'(m_clr && m_cnt == NW - 1 && !start_pic));
    chk("m_rd_valid", 32'(rd_data_valid), 32'(m_pend));
    if (m_pend && m_known) chk("m_rd_data", 32'(rd_data), 32'(m_pexp));
    chk("m_ram_en", 32'(ram_en), 32'(en));
    if (en) begin
      chk("m_ram_we", 32'(ram_we), 32'(we));
      chk("m_ram_addr", 32'(ram_addr), 32'(ea));
      if (we) chk("m_ram_wdata", 32'(ram_wdata), 32'(ed));
    end
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    m_pend = e_rd_acc;
    if (e_rd_acc) m_pexp = mmem[rd_addr];
    if (m_clr) begin
      if (start_pic) m_cnt = 0;
      else if (m_cnt == NW - 1) begin m_clr = 0; m_cnt = 0; m_known = 1; end
      else m_cnt++;
    end else if (start_pic) begin
      m_clr = 1; m_cnt = 0; mq.delete();
      for (int i = 0; i < NW; i++) mmem[i] = '0;
    end else begin
      if (!e_rd_acc && mq.size() > 0) void'(mq.pop_front());
      if (e_wr_acc) begin
        mq.push_back('{a: wr_addr, d: wr_data});
        mmem[wr_addr] = wr_data;
      end
    end
  endtask

  // Inputs are set just after a falling edge; checks land before the rising edge.
  task automatic cycle();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    start_pic = 0; rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0;
  endtask

  typedef struct {
    logic rd_req; logic [AB-1:0] rd_addr;
    logic wr_req; logic [AB-1:0] wr_addr; logic [DB-1:0] wr_data;
    logic rd_rdy; logic wr_rdy; logic vld; logic [DB-1:0] rdat;
    logic en; logic we; logic [AB-1:0] ra;
  } vec_t;
  vec_t tbl [10];

  initial begin
    tbl[0] = '{0, 0, 1, 3, 16'hABCD, 1, 1, 0, 16'h0,    0, 0, 0};
    tbl[1] = '{1, 3, 1, 1, 16'h1111, 0, 1, 0, 16'h0,    1, 1, 3};
    tbl[2] = '{1, 3, 1, 2, 16'h2222, 1, 1, 0, 16'h0,    1, 0, 3};
    tbl[3] = '{1, 1, 0, 0, 16'h0,    0, 1, 1, 16'hABCD, 1, 1, 1};
    tbl[4] = '{1, 1, 0, 0, 16'h0,    1, 1, 0, 16'h0,    1, 0, 1};
    tbl[5] = '{1, 2, 0, 0, 16'h0,    0, 1, 1, 16'h1111, 1, 1, 2};
    tbl[6] = '{1, 1, 0, 0, 16'h0,    1, 1, 0, 16'h0,    1, 0, 1};
    tbl[7] = '{1, 2, 0, 0, 16'h0,    1, 1, 1, 16'h1111, 1, 0, 2};
    tbl[8] = '{1, 3, 0, 0, 16'h0,    1, 1, 1, 16'h2222, 1, 0, 3};
    tbl[9] = '{0, 0, 0, 0, 16'h0,    1, 1, 1, 16'hABCD, 0, 0, 0};

    set_idle();
    rst = 1; scramble = 1;
    model_reset();
    repeat (2) @(negedge clk);
    scramble = 0; rst = 0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ram_en", 32'(ram_en), 32'd0);
    chk("reset_rd_valid", 32'(rd_data_valid), 32'd0);
    chk("reset_clear_done", 32'(clear_done), 32'd0);

    // Clear after reset
    start_pic = 1; cycle(); start_pic = 0;
    for (int i = 0; i < NW; i++) begin
      #1;
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_addr", 32'(ram_addr), 32'(i));
      chk("clr_done", 32'(clear_done), 32'(i == NW - 1));
      cycle();
    end
    rd_req = 1; rd_addr = 7; cycle(); rd_req = 0;
    #1;
    chk("clr_rd7_valid", 32'(rd_data_valid), 32'd1);
    chk("clr_rd7_data", 32'(rd_data), 32'd0);
    cycle();

    // Write-then-read hazard and back-to-back reads
    for (int i = 0; i < 10; i++) begin
      rd_req = tbl[i].rd_req; rd_addr = tbl[i].rd_addr;
      wr_req = tbl[i].wr_req; wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
      #1;
      chk($sformatf("tbl%0d_rd_ready", i), 32'(rd_ready), 32'(tbl[i].rd_rdy));
      chk($sformatf("tbl%0d_wr_ready", i), 32'(wr_ready), 32'(tbl[i].wr_rdy));
      chk($sformatf("tbl%0d_valid", i), 32'(rd_data_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(tbl[i].rdat));
      chk($sformatf("tbl%0d_ram_en", i), 32'(ram_en), 32'(tbl[i].en));
      if (tbl[i].en) begin
        chk($sformatf("tbl%0d_ram_we", i), 32'(ram_we), 32'(tbl[i].we));
        chk($sformatf("tbl%0d_ram_addr", i), 32'(ram_addr), 32'(tbl[i].ra));
      end
      cycle();
    end
    set_idle();

    // Read starvation: reads hog the port until the queue fills
    rd_req = 1; rd_addr = 0;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1; wr_addr = AB'(8 + i); wr_data = DB'(16'h8000 + i);
      #1 chk("starve_wr_ready", 32'(wr_ready), 32'd1);
      cycle();
    end
    wr_req = 0;
    #1;
    chk("starve_rd_ready_full", 32'(rd_ready), 32'd0);
    chk("starve_drain_we", 32'(ram_we), 32'd1);
    chk("starve_drain_addr", 32'(ram_addr), 32'd8);
    cycle();
    #1 chk("starve_rd_accept", 32'(rd_ready), 32'd1);
    cycle();
    rd_req = 0;
    repeat (5) cycle();
    for (int i = 0; i < 4; i++) chk("starve_mem", 32'(mem[8 + i]), 32'(16'h8000 + i));

    // start_pic in READY with queued writes and a same-cycle read
    wr_req = 1; wr_addr = 12; wr_data = 16'h0C0C; cycle();
    wr_req = 0; cycle(); cycle();
    rd_req = 1; rd_addr = 0;
    wr_req = 1; wr_addr = 5; wr_data = 16'h5555; cycle();
    wr_addr = 6; wr_data = 16'h6666; cycle();
    wr_req = 0; start_pic = 1; rd_addr = 12;
    #1 chk("sp_rd_ready", 32'(rd_ready), 32'd1);
    cycle();
    start_pic = 0; rd_req = 0;
    #1;
    chk("sp_rd_valid", 32'(rd_data_valid), 32'd1);
    chk("sp_rd_data", 32'(rd_data), 32'h0C0C);
    cycle();
    repeat (15) cycle();
    chk("sp_mem5", 32'(mem[5]), 32'd0);
    chk("sp_mem6", 32'(mem[6]), 32'd0);
    for (int i = 0; i <= NW; i++) begin
      rd_req = (i < NW); rd_addr = AB'(i);
      #1 if (i > 0) chk("sp_zero", 32'(rd_data), 32'd0);
      cycle();
    end
    set_idle();

    // start_pic mid-sweep at counter 9
    start_pic = 1; cycle(); start_pic = 0;
    repeat (9) cycle();
    #1 chk("restart_at9", 32'(ram_addr), 32'd9);
    done_seen = 0;
    start_pic = 1; cycle(); start_pic = 0;
    #1 chk("restart_addr0", 32'(ram_addr), 32'd0);
    repeat (16) cycle();
    chk("restart_one_done", 32'(done_seen), 32'd1);
    #1 chk("restart_idle", 32'(busy), 32'd0);

    // rst mid-sweep
    start_pic = 1; cycle(); start_pic = 0;
    repeat (5) cycle();
    #2 rst = 1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ram_en", 32'(ram_en), 32'd0);
    cycle();
    rst = 0;
    cycle();
    start_pic = 1; cycle(); start_pic = 0;
    repeat (16) cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      rd_req    = ($urandom_range(0, 9) < 6);
      rd_addr   = AB'($urandom_range(0, NW - 1));
      wr_req    = ($urandom_range(0, 9) < 5);
      wr_addr   = AB'($urandom_range(0, NW - 1));
      wr_data   = DB'($urandom);
      start_pic = ($urandom_range(0, 299) == 0);
      cycle();
    end
    set_idle();
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
